// File: rtl/strength_resolver.sv
// Multi-driver net strength resolver with optional charge-hold decay.
// One registered result per accepted driver set, valid/ready on both sides.
module strength_resolver #(
  parameter int WIDTH = 8,
  parameter int NDRV  = 3,
  parameter int DECAY = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NDRV*WIDTH*2-1:0] drv_val,
  input  logic [NDRV*3-1:0]       drv_str,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH*2-1:0]      out_val,
  output logic [WIDTH-1:0]        out_conflict,
  output logic [15:0]             conflict_cnt,
  input  logic                    clr_cnt
);

  localparam int CW = (DECAY > 0) ? $clog2(DECAY + 1) : 1;
  localparam logic [CW-1:0] DECAY_L = CW'(DECAY);

  logic                     in_fire;
  logic [WIDTH*2-1:0]       res_val;
  logic [WIDTH-1:0]         res_conf;
  logic [WIDTH-1:0]         res_present;
  logic [WIDTH*2-1:0]       fin_val;
  logic [WIDTH*2-1:0]       chg_val;
  logic [WIDTH-1:0]         chg_ok;
  logic [WIDTH-1:0][CW-1:0] hold_cnt;

  logic [2:0] maxs;
  logic [2:0] s;
  logic [1:0] code;
  logic       has0, has1, hasx;

  assign in_ready = !out_valid || out_ready;
  assign in_fire  = in_valid && in_ready;

  // Two passes per bit: find the winning strength, then classify its participants.
  always_comb begin
    res_val     = '0;
    res_conf    = '0;
    res_present = '0;
    maxs = '0;
    s    = '0;
    code = '0;
    has0 = 1'b0;
    has1 = 1'b0;
    hasx = 1'b0;
    for (int unsigned b = 0; b < WIDTH; b++) begin
      maxs = '0;
      has0 = 1'b0;
      has1 = 1'b0;
      hasx = 1'b0;
      for (int unsigned d = 0; d < NDRV; d++) begin
        code = drv_val[d*WIDTH*2 + b*2 +: 2];
        s    = drv_str[d*3 +: 3];
        if (code != 2'b11 && s != 3'd0 && s > maxs) maxs = s;
      end
      for (int unsigned d = 0; d < NDRV; d++) begin
        code = drv_val[d*WIDTH*2 + b*2 +: 2];
        s    = drv_str[d*3 +: 3];
        if (code != 2'b11 && s != 3'd0 && s == maxs) begin
          case (code)
            2'b00:   has0 = 1'b1;
            2'b01:   has1 = 1'b1;
            default: hasx = 1'b1;
          endcase
        end
      end
      res_present[b] = (maxs != 3'd0);
      res_conf[b]    = has0 && has1;
      if (maxs == 3'd0)            res_val[b*2 +: 2] = 2'b11;
      else if (hasx || (has0 && has1)) res_val[b*2 +: 2] = 2'b10;
      else if (has1)               res_val[b*2 +: 2] = 2'b01;
      else                         res_val[b*2 +: 2] = 2'b00;
    end
  end

  // Undriven bits fall back to stored charge, which decays to x after DECAY holds.
  always_comb begin
    fin_val = '0;
    for (int unsigned b = 0; b < WIDTH; b++) begin
      if (res_present[b])                 fin_val[b*2 +: 2] = res_val[b*2 +: 2];
      else if (DECAY == 0 || !chg_ok[b])  fin_val[b*2 +: 2] = 2'b11;
      else if (hold_cnt[b] < DECAY_L)     fin_val[b*2 +: 2] = chg_val[b*2 +: 2];
      else                                fin_val[b*2 +: 2] = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chg_val  <= '1;
      chg_ok   <= '0;
      hold_cnt <= '0;
    end else if (in_fire) begin
      for (int unsigned b = 0; b < WIDTH; b++) begin
        if (res_present[b]) begin
          chg_val[b*2 +: 2] <= res_val[b*2 +: 2];
          chg_ok[b]         <= 1'b1;
          hold_cnt[b]       <= '0;
        end else if (chg_ok[b] && hold_cnt[b] < DECAY_L) begin
          hold_cnt[b] <= hold_cnt[b] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_val      <= '1;
      out_conflict <= '0;
    end else if (in_fire) begin
      out_valid    <= 1'b1;
      out_val      <= fin_val;
      out_conflict <= res_conf;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      conflict_cnt <= '0;
    else if (clr_cnt)
      conflict_cnt <= '0;
    else if (in_fire && (|res_conf) && conflict_cnt != 16'hFFFF)
      conflict_cnt <= conflict_cnt + 16'd1;
  end

endmodule

// File: tb/tb_strength_resolver.sv
// Directed bench for strength_resolver (WIDTH=4, NDRV=3, DECAY=2).
module tb_strength_resolver;

  localparam logic [7:0] A0 = 8'h00;
  localparam logic [7:0] A1 = 8'h55;
  localparam logic [7:0] AX = 8'hAA;
  localparam logic [7:0] AZ = 8'hFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] drv_val;
  logic [8:0]  drv_str;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_val;
  logic [3:0]  out_conflict;
  logic [15:0] conflict_cnt;
  logic        clr_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  strength_resolver #(.WIDTH(4), .NDRV(3), .DECAY(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .drv_val(drv_val), .drv_str(drv_str), .out_valid(out_valid),
    .out_ready(out_ready), .out_val(out_val), .out_conflict(out_conflict),
    .conflict_cnt(conflict_cnt), .clr_cnt(clr_cnt)
  );

  always #5 clk = ~clk;

  task automatic set_drv(input logic [7:0] v0, v1, v2, input logic [2:0] s0, s1, s2);
    drv_val = {v2, v1, v0};
    drv_str = {s2, s1, s0};
  endtask

  task automatic send(input logic [7:0] v0, v1, v2, input logic [2:0] s0, s1, s2);
    set_drv(v0, v1, v2, s0, s1, s2);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
    set_drv(AZ, AZ, AZ, 3'd0, 3'd0, 3'd0);
    #12;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    n_chk++; if (out_val !== AZ) begin n_fail++; $display("FAIL reset_val got=%h exp=%h", out_val, AZ); end
    n_chk++; if (out_conflict !== 4'h0) begin n_fail++; $display("FAIL reset_conf got=%h exp=0", out_conflict); end
    n_chk++; if (conflict_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_cnt got=%h exp=0", conflict_cnt); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_first_absent;
    // value 1 with strength 0, and z at supply: all absent, no charge yet
    send(A1, AZ, AZ, 3'd0, 3'd7, 3'd7);
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL absent_valid got=%b exp=1", out_valid); end
    n_chk++; if (out_val !== AZ) begin n_fail++; $display("FAIL absent_val got=%h exp=%h", out_val, AZ); end
  endtask

  task automatic test_resolve;
    send(A0, A1, AX, 3'd3, 3'd5, 3'd6);
    n_chk++; if (out_val !== AX) begin n_fail++; $display("FAIL strong_x_val got=%h exp=%h", out_val, AX); end
    n_chk++; if (out_conflict !== 4'h0) begin n_fail++; $display("FAIL strong_x_conf got=%h exp=0", out_conflict); end
    n_chk++; if (conflict_cnt !== 16'd0) begin n_fail++; $display("FAIL strong_x_cnt got=%h exp=0", conflict_cnt); end
    send(A0, A1, AZ, 3'd3, 3'd5, 3'd0);
    n_chk++; if (out_val !== A1) begin n_fail++; $display("FAIL pull1_val got=%h exp=%h", out_val, A1); end
    n_chk++; if (out_conflict !== 4'h0) begin n_fail++; $display("FAIL pull1_conf got=%h exp=0", out_conflict); end
    send(A0, A1, A0, 3'd3, 3'd5, 3'd5);
    n_chk++; if (out_val !== AX) begin n_fail++; $display("FAIL pull_tie_val got=%h exp=%h", out_val, AX); end
    n_chk++; if (out_conflict !== 4'hF) begin n_fail++; $display("FAIL pull_tie_conf got=%h exp=f", out_conflict); end
    n_chk++; if (conflict_cnt !== 16'd1) begin n_fail++; $display("FAIL pull_tie_cnt got=%h exp=1", conflict_cnt); end
  endtask

  task automatic test_mixed_bits;
    // b0: 0/0 supply ->0; b1: 1/0 supply ->x conflict; b2: only small 1 ->1; b3: supply 0 beats small 1
    send(8'b11_11_01_00, 8'b00_11_00_00, A1, 3'd7, 3'd7, 3'd2);
    n_chk++; if (out_val !== 8'h18) begin n_fail++; $display("FAIL mixed_val got=%h exp=18", out_val); end
    n_chk++; if (out_conflict !== 4'b0010) begin n_fail++; $display("FAIL mixed_conf got=%b exp=0010", out_conflict); end
    n_chk++; if (conflict_cnt !== 16'd2) begin n_fail++; $display("FAIL mixed_cnt got=%h exp=2", conflict_cnt); end
    send(AX, AX, A0, 3'd5, 3'd5, 3'd4);
    n_chk++; if (out_val !== AX) begin n_fail++; $display("FAIL xtie_val got=%h exp=%h", out_val, AX); end
    n_chk++; if (out_conflict !== 4'h0) begin n_fail++; $display("FAIL xtie_conf got=%h exp=0", out_conflict); end
    n_chk++; if (conflict_cnt !== 16'd2) begin n_fail++; $display("FAIL xtie_cnt got=%h exp=2", conflict_cnt); end
  endtask

  task automatic test_decay;
    logic [7:0] exp_seq [4];
    exp_seq[0] = A1; exp_seq[1] = A1; exp_seq[2] = A1; exp_seq[3] = AX;
    send(A1, AZ, AZ, 3'd6, 3'd0, 3'd0);
    n_chk++; if (out_val !== exp_seq[0]) begin n_fail++; $display("FAIL decay0 got=%h exp=%h", out_val, exp_seq[0]); end
    for (int i = 1; i < 4; i++) begin
      send(AZ, AZ, AZ, 3'd0, 3'd0, 3'd0);
      n_chk++; if (out_val !== exp_seq[i]) begin n_fail++; $display("FAIL decay%0d got=%h exp=%h", i, out_val, exp_seq[i]); end
    end
    send(AZ, AZ, AZ, 3'd0, 3'd0, 3'd0);
    n_chk++; if (out_val !== AX) begin n_fail++; $display("FAIL decay_hold got=%h exp=%h", out_val, AX); end
  endtask

  task automatic test_backpressure;
    @(posedge clk); #1;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid got=%b exp=0", out_valid); end
    out_ready = 1'b0;
    send(A0, AZ, AZ, 3'd6, 3'd0, 3'd0);
    set_drv(A1, AZ, AZ, 3'd6, 3'd0, 3'd0);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready%0d got=%b exp=0", i, in_ready); end
      n_chk++; if (out_val !== A0 || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL stall_hold%0d got=%h/%b exp=%h/1", i, out_val, out_valid, A0); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    n_chk++; if (out_val !== A1) begin n_fail++; $display("FAIL b2b_first got=%h exp=%h", out_val, A1); end
    set_drv(AX, AZ, AZ, 3'd6, 3'd0, 3'd0);
    @(posedge clk); #1;
    n_chk++; if (out_val !== AX) begin n_fail++; $display("FAIL b2b_second got=%h exp=%h", out_val, AX); end
    set_drv(A0, AZ, AZ, 3'd6, 3'd0, 3'd0);
    @(posedge clk); #1;
    n_chk++; if (out_val !== A0 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL b2b_third got=%h/%b exp=%h/1", out_val, out_valid, A0); end
    in_valid = 1'b0;
  endtask

  task automatic test_saturation;
    set_drv(A1, A0, AZ, 3'd5, 3'd5, 3'd0);
    in_valid = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      @(posedge clk); #1;
      if (conflict_cnt == 16'hFFFF) break;
    end
    n_chk++; if (conflict_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach got=%h exp=ffff", conflict_cnt); end
    @(posedge clk); #1;
    n_chk++; if (conflict_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got=%h exp=ffff", conflict_cnt); end
    n_chk++; if (out_conflict !== 4'hF) begin n_fail++; $display("FAIL sat_conf got=%h exp=f", out_conflict); end
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (conflict_cnt !== 16'h0) begin n_fail++; $display("FAIL clr_prio got=%h exp=0", conflict_cnt); end
    clr_cnt = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (conflict_cnt !== 16'h1) begin n_fail++; $display("FAIL post_clr got=%h exp=1", conflict_cnt); end
    in_valid = 1'b0;
  endtask

  task automatic test_async_reset;
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(A1, AZ, AZ, 3'd6, 3'd0, 3'd0);
    n_chk++; if (out_valid !== 1'b1 || out_val !== A1) begin
      n_fail++; $display("FAIL pre_rst got=%h/%b exp=%h/1", out_val, out_valid, A1); end
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid got=%b exp=0", out_valid); end
    n_chk++; if (out_val !== AZ) begin n_fail++; $display("FAIL arst_val got=%h exp=%h", out_val, AZ); end
    n_chk++; if (conflict_cnt !== 16'h0) begin n_fail++; $display("FAIL arst_cnt got=%h exp=0", conflict_cnt); end
    out_ready = 1'b1;
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(AZ, AZ, AZ, 3'd0, 3'd0, 3'd0);
    n_chk++; if (out_val !== AZ || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL post_rst_charge got=%h/%b exp=%h/1", out_val, out_valid, AZ); end
  endtask

  initial begin
    test_reset;
    test_first_absent;
    test_resolve;
    test_mixed_bits;
    test_decay;
    test_backpressure;
    test_saturation;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
